// File: rtl/lsnn_pkg.sv
// lsnn_pkg -- shared definitions for the adaptive LIF neuron array.
//   state_e      : controller states (IDLE -> UPDATE -> DONE -> IDLE)
//   sat_add      : unsigned add clamped to 2^w-1 (w <= 32)
//   adapt_decay  : a -> (a >> 1) + (a >> 2), adaptation leak without a spike
//   adapt_grow   : a -> sat(a + (a >> 2)), adaptation boost after a spike
package lsnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Helpers work on 32-bit containers so one function serves every WIDTH;
  // callers slice the low WIDTH bits, which always hold the full result.
  function automatic logic [31:0] sat_add(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, x} + {1'b0, y};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  // 0.75 * a never exceeds a, so no clamp is needed.
  function automatic logic [31:0] adapt_decay(input logic [31:0] x);
    return (x >> 1) + (x >> 2);
  endfunction

  function automatic logic [31:0] adapt_grow(input logic [31:0] x,
                                             input int unsigned w);
    return sat_add(x, x >> 2, w);
  endfunction

endpackage

// File: rtl/lsnn_neuron_update.sv
// lsnn_neuron_update -- combinational next-state for one adaptive LIF neuron.
// Shared by all neurons of lsnn_array; the caller muxes in the state of the
// neuron being updated and writes the results back.
//   cur_i   : input current for this sample
//   v_i/a_i : membrane / adaptation before the update
//   ref_i   : refractory samples remaining
//   v_o/a_o/ref_o : state after the update
//   spike_o : neuron fired on this sample
module lsnn_neuron_update
  import lsnn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int B0     = 8,
  parameter int REFRAC = 2,
  parameter int RW     = 2
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [RW-1:0]    ref_i,
  output logic [WIDTH-1:0] v_o,
  output logic [WIDTH-1:0] a_o,
  output logic [RW-1:0]    ref_o,
  output logic             spike_o
);

  logic [31:0]      thr_w;
  logic [31:0]      vp_w;
  logic [31:0]      grow_w;
  logic [31:0]      decay_w;
  logic [WIDTH-1:0] thr;
  logic [WIDTH-1:0] vp;
  logic             unused_hi;

  always_comb begin
    thr_w   = sat_add(32'(B0), 32'(a_i), WIDTH);
    vp_w    = sat_add(32'(cur_i), 32'(v_i >> 1), WIDTH);
    grow_w  = adapt_grow(32'(a_i), WIDTH);
    decay_w = adapt_decay(32'(a_i));
    thr     = thr_w[WIDTH-1:0];
    vp      = vp_w[WIDTH-1:0];

    spike_o = 1'b0;
    v_o     = vp;
    a_o     = decay_w[WIDTH-1:0];
    ref_o   = ref_i;

    if (ref_i != '0) begin
      // Refractory: input is ignored and the membrane only leaks.
      v_o   = v_i >> 1;
      ref_o = ref_i - RW'(1);
    end else if (vp >= thr) begin
      spike_o = 1'b1;
      v_o     = '0;
      a_o     = grow_w[WIDTH-1:0];
      ref_o   = RW'(REFRAC);
    end
  end

  // Upper bits of the 32-bit helper results are always zero.
  assign unused_hi = ^{thr_w, vp_w, grow_w, decay_w};

endmodule

// File: rtl/lsnn_array.sv
// lsnn_array -- array of N_NEURONS adaptive LIF neurons sharing one update
// datapath. A sample is captured in IDLE, the neurons are updated one per
// cycle in UPDATE, and the spike vector is offered in DONE.
//   clk, rst_n      : clock; synchronous reset, active HIGH despite the name
//   in_valid/ready  : sample input handshake, in_current packed per neuron
//   out_valid/ready : spike vector handshake, spike_out bit i = neuron i
//   thresh_sel/out  : combinational view of sat(B0 + a) for one neuron
//   dbg_state_o     : controller state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, and
// spike_out is held there until out_ready. in_valid outside IDLE is ignored.
module lsnn_array
  import lsnn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int B0        = 8,
  parameter int ALPHA0    = 8,
  parameter int REFRAC    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_NEURONS*WIDTH-1:0]   in_current,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS-1:0]         spike_out,
  input  logic [$clog2(N_NEURONS)-1:0] thresh_sel,
  output logic [WIDTH-1:0]             thresh_out,
  output state_e                       dbg_state_o
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q;
  logic [N_NEURONS*WIDTH-1:0]   cur_q;
  logic [N_NEURONS-1:0]         spike_q;
  logic [WIDTH-1:0]             v_q   [N_NEURONS];
  logic [WIDTH-1:0]             a_q   [N_NEURONS];
  logic [RW-1:0]                ref_q [N_NEURONS];

  logic [WIDTH-1:0]             nu_v, nu_a;
  logic [RW-1:0]                nu_ref;
  logic                         nu_spike;
  logic [31:0]                  thr_sel_w;
  logic                         unused_thr;

  lsnn_neuron_update #(
    .WIDTH  (WIDTH),
    .B0     (B0),
    .REFRAC (REFRAC),
    .RW     (RW)
  ) u_update (
    .cur_i   (cur_q[idx_q*WIDTH +: WIDTH]),
    .v_i     (v_q[idx_q]),
    .a_i     (a_q[idx_q]),
    .ref_i   (ref_q[idx_q]),
    .v_o     (nu_v),
    .a_o     (nu_a),
    .ref_o   (nu_ref),
    .spike_o (nu_spike)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_UPDATE;
      ST_UPDATE: if (idx_q == IW'(N_NEURONS - 1)) state_d = ST_DONE;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cur_q   <= '0;
      spike_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]   <= '0;
        a_q[i]   <= WIDTH'(ALPHA0);
        ref_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cur_q   <= in_current;
            idx_q   <= '0;
            spike_q <= '0;
          end
        end
        ST_UPDATE: begin
          v_q[idx_q]     <= nu_v;
          a_q[idx_q]     <= nu_a;
          ref_q[idx_q]   <= nu_ref;
          spike_q[idx_q] <= nu_spike;
          // N_NEURONS is a power of two, so the last increment wraps to 0.
          idx_q          <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign spike_out   = spike_q;
  assign dbg_state_o = state_q;

  assign thr_sel_w  = sat_add(32'(B0), 32'(a_q[thresh_sel]), WIDTH);
  assign thresh_out = thr_sel_w[WIDTH-1:0];
  assign unused_thr = ^thr_sel_w;

endmodule
